pwm_audio_capture: RTL
======================

Name: pwm_audio_capture

Overview:
- Receive-side counterpart of the 8-bit PWM audio output.
- Takes an asynchronous 1-bit PWM stream with a fixed period of PERIOD clocks and recovers the 8-bit sample by counting high cycles over each frame.
- Presents each recovered sample on a valid/ready interface.
- Used for loopback self-test and for ingesting PWM audio from an external chip.

Parameters:
- PERIOD, 255, PWM frame length in clocks; legal range 2..255. The recovered sample equals the high-cycle count, unscaled.
- SYNC_STAGES, 2, synchroniser flops on pwm_in; legal range 2..3.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- pwm_in  input  1  asynchronous PWM stream
- sample  output  8  recovered sample (high-cycle count of the last frame)
- sample_valid  output  1  sample holds an unconsumed result
- sample_ready  input  1  consumer accepts sample when high together with sample_valid
- overrun  output  1  one-cycle pulse when an unconsumed result is overwritten
- stable  output  1  last two delivered frame results were equal

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - sample=0, sample_valid=0, overrun=0, stable=0.
  - Synchroniser flops=0, frame_cnt=0, acc=0.
  - warm=0; warm is an internal flag marking that the first full frame has been skipped.
  - Reset asserted mid-frame discards the partial frame and acc.
- Synchroniser: SYNC_STAGES flops; s_bit is the last stage output. s_bit lags pwm_in by SYNC_STAGES cycles.
- Frame counter: frame_cnt counts 0..PERIOD-1 and wraps to 0. It is free-running and not phase-aligned to the transmitter.
- Accumulator:
  - Each cycle with frame_cnt != PERIOD-1: acc <= acc + s_bit. acc is 8 bits and never exceeds PERIOD-1 inside a frame.
  - At frame_cnt == PERIOD-1 (frame end): result = acc + s_bit (max PERIOD, at most 255, no overflow); acc <= 0.
- Phase independence: for a steady input, any PERIOD-cycle window of a PERIOD-periodic wave contains exactly that sample's high count. The result is therefore exact regardless of frame alignment. A sample change mid-frame yields one intermediate value.
- Warm-up: the first frame end after reset only sets warm=1. Its result is discarded because the synchroniser was filling during that frame.
- Delivery, at frame end with warm=1:
  - sample <= result; sample_valid <= 1 on the next edge. Latency is 1 cycle from frame end.
  - If sample_valid=1 and sample_ready=0 at that edge: sample is overwritten, overrun pulses 1 cycle, sample_valid stays 1.
  - If sample_valid & sample_ready coincide with frame end: the handshake completes, the new result loads, sample_valid stays 1, and no overrun.
- Handshake:
  - sample_valid clears on the edge after sample_valid & sample_ready, when no new result arrives.
  - sample is stable while sample_valid=1 and not accepted, except for an overrun overwrite.
- stable:
  - Updated at each delivery: stable <= (result == previous delivered result).
  - Cleared by reset.
  - The first delivery after reset sets stable=0.
- Boundaries:
  - pwm_in constantly 0 yields sample=0.
  - pwm_in constantly 1 yields sample=PERIOD (255 at default).
  - No edges are required for either case.

Optional Feature:
- Macro PWM_CAPTURE_DEGLITCH_EN.
- Defined:
  - A 3-tap majority filter on s_bit feeds the accumulator, adding 2 cycles of latency.
  - Single-cycle glitches on a steady level are rejected.
  - A legitimate 1-cycle-high (sample=1) pulse is also suppressed; this is documented and accepted.
- Undefined: s_bit feeds the accumulator directly.
- Port list is identical in both builds.

Decomposition:
- Shared package pwm_audio_pkg:
  - PWM_PERIOD = 255
  - PWM_SAMPLE_W = 8
  - typedef pwm_sample_t (logic [7:0])
- Sub-module pwm_sync: generic N-stage bit synchroniser with reset, reusable for other async inputs.
- Majority filter stays inline.

Test Plan:
- Loopback: drive pwm_in from the PWM audio output (its reset = ~rst) with sample=0x80 and random start phase. After warm-up, every delivered sample=0x80, stable=1 from the second delivery on, overrun never pulses with sample_ready tied 1.
- Extremes: pwm_in held 0, then held 1. Delivered samples are 0x00, then 0xFF after at most one intermediate value. Also cover sample=1 and sample=254 via loopback, which deliver exactly 1 and 254 (macro undefined).
- Backpressure: sample_ready=0 across two frame ends with input 0x40 then 0x41. Expect overrun pulse on the second delivery, sample=0x41, sample_valid held. Then raise sample_ready for 1 cycle: sample_valid drops the next cycle.
- Coincident accept and frame end: sample_ready asserted exactly at a frame-end edge. Expect new value loaded, sample_valid remaining 1, no overrun.
- Reset mid-frame: assert rst at frame_cnt=100 for 1 cycle. Expect all outputs 0, the first frame end afterwards delivering nothing, and the second delivering the correct value.
- PWM_CAPTURE_DEGLITCH_EN build: 0x00 stream with single-cycle high glitches every 50 cycles. Delivered sample=0x00; the undefined build delivers a nonzero value.

Source files
------------

// File: rtl/pwm_audio_pkg.sv
// Shared types and constants for the PWM audio capture path.
package pwm_audio_pkg;

  localparam int PWM_PERIOD   = 255;
  localparam int PWM_SAMPLE_W = 8;

  typedef logic [PWM_SAMPLE_W-1:0] pwm_sample_t;

  // Delivery phase after reset: skip one frame, deliver one without a
  // comparison partner, then run with the stable comparison active.
  typedef enum logic [1:0] {
    CAP_WARMUP = 2'd0,
    CAP_FIRST  = 2'd1,
    CAP_RUN    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_sync.sv
// Generic N-stage bit synchroniser with synchronous active-high reset.
module pwm_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pwm_audio_capture.sv
// Recovers 8-bit samples from a free-running PWM stream by counting high cycles per frame.
// Optional build macro PWM_CAPTURE_DEGLITCH_EN inserts a 3-tap majority filter before the accumulator.
module pwm_audio_capture
  import pwm_audio_pkg::*;
#(
  parameter int PERIOD      = PWM_PERIOD,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output pwm_sample_t sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        stable
);

  localparam pwm_sample_t LAST_CNT = pwm_sample_t'(PERIOD - 1);

  logic        s_bit;
  logic        acc_bit;
  pwm_sample_t frame_cnt;
  pwm_sample_t acc;
  pwm_sample_t result;
  logic        frame_end;
  logic        deliver;
  logic        compare_en;
  cap_state_t  state;
  cap_state_t  state_next;

  pwm_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pwm_in),
    .q   (s_bit)
  );

`ifdef PWM_CAPTURE_DEGLITCH_EN
  logic tap1;
  logic tap2;
  logic filt;

  // Registered majority of the newest three synchronised bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap1 <= 1'b0;
      tap2 <= 1'b0;
      filt <= 1'b0;
    end else begin
      tap1 <= s_bit;
      tap2 <= tap1;
      filt <= (s_bit & tap1) | (s_bit & tap2) | (tap1 & tap2);
    end
  end

  assign acc_bit = filt;
`else
  assign acc_bit = s_bit;
`endif

  assign frame_end = (frame_cnt == LAST_CNT);
  // acc stays below PERIOD inside a frame, so the closing add cannot wrap.
  assign result    = acc + {{(PWM_SAMPLE_W-1){1'b0}}, acc_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CAP_WARMUP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    deliver    = 1'b0;
    compare_en = 1'b0;
    case (state)
      CAP_WARMUP: begin
        if (frame_end) state_next = CAP_FIRST;
      end
      CAP_FIRST: begin
        deliver = frame_end;
        if (frame_end) state_next = CAP_RUN;
      end
      CAP_RUN: begin
        deliver    = frame_end;
        compare_en = 1'b1;
      end
      default: begin
        state_next = CAP_WARMUP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      acc       <= '0;
    end else if (frame_end) begin
      frame_cnt <= '0;
      acc       <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
      acc       <= result;
    end
  end

  // Valid/ready: a sample transfers on any edge where sample_valid and
  // sample_ready are both high; sample holds until then unless a newer
  // result overwrites it (flagged by overrun when it was not taken).
  always_ff @(posedge clk) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      stable       <= 1'b0;
    end else begin
      overrun <= deliver & sample_valid & ~sample_ready;
      if (deliver) begin
        sample       <= result;
        sample_valid <= 1'b1;
        // sample still holds the previous delivery at this point.
        stable       <= compare_en & (result == sample);
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule
